// File: rtl/fpcvt_pkg.sv
// rtl/fpcvt_pkg.sv - shared types, constants and width helper for the sequential int-to-float converter
//
// Contents:
//   state_e      FSM state encoding (IDLE, ABS, NORM, ROUND, DONE)
//   RND_TRUNC    rounding-mode select value for truncation
//   RND_HALFUP   rounding-mode select value for round-half-up
//   dw_of()      input word width derived from mantissa and exponent widths
package fpcvt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ABS   = 3'd1,
        ST_NORM  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic RND_TRUNC  = 1'b0;
    localparam logic RND_HALFUP = 1'b1;

    // The input spans FW mantissa bits plus one bit per possible exponent
    // step, so a fully normalised magnitude always fits the shifter.
    function automatic int dw_of(input int fw, input int ew);
        return fw + (1 << ew);
    endfunction

endpackage

// File: rtl/fpcvt_round.sv
// rtl/fpcvt_round.sv - combinational mantissa increment with overflow renormalise and saturation
//
// Ports:
//   f_i    [FW-1:0]  truncated mantissa
//   e_i    [EW-1:0]  exponent after normalisation
//   inc_i            add one ulp to the mantissa
//   f_o    [FW-1:0]  rounded mantissa
//   e_o    [EW-1:0]  rounded exponent
module fpcvt_round
    import fpcvt_pkg::*;
#(
    parameter int FW = 4,
    parameter int EW = 3
) (
    input  logic [FW-1:0] f_i,
    input  logic [EW-1:0] e_i,
    input  logic          inc_i,
    output logic [FW-1:0] f_o,
    output logic [EW-1:0] e_o
);

    localparam logic [EW-1:0] E_MAX = '1;
    localparam logic [FW-1:0] F_MAX = '1;
    // Leading one only: the value after a carry out of the mantissa.
    localparam logic [FW-1:0] F_HALF = {1'b1, {(FW-1){1'b0}}};

    logic [FW:0] sum;

    always_comb begin
        sum = {1'b0, f_i} + {{FW{1'b0}}, inc_i};
        f_o = sum[FW-1:0];
        e_o = e_i;
        if (sum[FW]) begin
            // A carry out of the mantissa doubles the value: shift it back
            // into range by bumping the exponent, unless there is no room.
            if (e_i == E_MAX) begin
                f_o = F_MAX;
                e_o = E_MAX;
            end else begin
                f_o = F_HALF;
                e_o = e_i + EW'(1);
            end
        end
    end

endmodule

// File: rtl/fpcvt_seq.sv
// rtl/fpcvt_seq.sv - sequential two's-complement to floating-point converter (value = F * 2^E)
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   input word valid
//   in_ready_o   converter can accept (IDLE only)
//   in_data_i    [DW-1:0] two's-complement input
//   in_rnd_i     0 = truncate, 1 = round-half-up, sampled with in_data_i
//   out_valid_o  result valid, held until out_ready_i
//   out_ready_i  consumer accepts result
//   out_s_o      sign
//   out_e_o      [EW-1:0] exponent
//   out_f_o      [FW-1:0] mantissa
module fpcvt_seq
    import fpcvt_pkg::*;
#(
    parameter  int FW = 4,
    parameter  int EW = 3,
    localparam int DW = dw_of(FW, EW)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    input  logic          in_rnd_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic          out_s_o,
    output logic [EW-1:0] out_e_o,
    output logic [FW-1:0] out_f_o
);

    // Magnitude width: the sign bit is dropped after ABS.
    localparam int MW = DW - 1;
    localparam logic [EW-1:0] E_MAX = '1;

    state_e        state_q;
    logic [DW-1:0] data_q;
    logic          rnd_q;
    logic          s_q;
    logic [MW-1:0] mag_q;
    logic [EW-1:0] e_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          out_s_q;
    logic [EW-1:0] out_e_q;
    logic [FW-1:0] out_f_q;

    logic [MW-1:0] mag_d;
    logic [FW-1:0] trunc_f;
    logic          round_bit;
    logic          round_inc;
    logic [FW-1:0] rnd_f;
    logic [EW-1:0] rnd_e;

    // Absolute value over MW bits only: every representable |x| except the
    // most negative input fits, and that one case saturates to all ones.
    always_comb begin
        mag_d = data_q[MW-1:0];
        if (data_q[DW-1]) begin
            if (data_q[MW-1:0] == '0) begin
                mag_d = '1;
            end else begin
                mag_d = (~data_q[MW-1:0]) + MW'(1);
            end
        end
    end

    assign trunc_f   = mag_q[MW-1 -: FW];
    assign round_bit = mag_q[MW-1-FW];
    assign round_inc = (rnd_q == RND_HALFUP) && round_bit;

    fpcvt_round #(
        .FW (FW),
        .EW (EW)
    ) u_round (
        .f_i   (trunc_f),
        .e_i   (e_q),
        .inc_i (round_inc),
        .f_o   (rnd_f),
        .e_o   (rnd_e)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            rnd_q       <= 1'b0;
            s_q         <= 1'b0;
            mag_q       <= '0;
            e_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_s_q     <= 1'b0;
            out_e_q     <= '0;
            out_f_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // in_ready stays low during reset and rises on the
                    // first edge after it is released.
                    in_ready_q <= 1'b1;
                    if (in_valid_i && in_ready_q) begin
                        data_q     <= in_data_i;
                        rnd_q      <= in_rnd_i;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_ABS;
                    end
                end
                ST_ABS: begin
                    s_q     <= data_q[DW-1];
                    mag_q   <= mag_d;
                    e_q     <= E_MAX;
                    state_q <= ST_NORM;
                end
                ST_NORM: begin
                    // Stop at the leading one, or at e == 0 where the
                    // result is left denormal (this also covers zero).
                    if (!mag_q[MW-1] && (e_q != '0)) begin
                        mag_q <= {mag_q[MW-2:0], 1'b0};
                        e_q   <= e_q - EW'(1);
                    end else begin
                        state_q <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    out_s_q     <= s_q;
                    out_e_q     <= rnd_e;
                    out_f_q     <= rnd_f;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_s_o     = out_s_q;
    assign out_e_o     = out_e_q;
    assign out_f_o     = out_f_q;

endmodule

// File: tb/tb_fpcvt_seq.sv
// tb/tb_fpcvt_seq.sv - self-checking bench for fpcvt_seq with directed vectors and a random reference-model sweep
module tb_fpcvt_seq;
    import fpcvt_pkg::*;

    localparam int FW = 4;
    localparam int EW = 3;
    localparam int DW = FW + (1 << EW);

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_rnd;
    logic          out_valid;
    logic          out_ready;
    logic          out_s;
    logic [EW-1:0] out_e;
    logic [FW-1:0] out_f;

    int checks;
    int failures;

    fpcvt_seq #(
        .FW (FW),
        .EW (EW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_rnd_i    (in_rnd),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_s_o     (out_s),
        .out_e_o     (out_e),
        .out_f_o     (out_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // value = F * 2^E: normalise |x| so its leading one sits at the top of
    // the DW-1 bit magnitude, limited to 2^EW-1 steps; the steps taken are
    // subtracted from the maximum exponent and set the latency.
    task automatic model(input logic [DW-1:0] d, input logic r,
                         output logic s, output logic [EW-1:0] e,
                         output logic [FW-1:0] f, output int lat);
        int v, mag, p, sh, norm, fi, ei, rb;
        v   = int'($signed(d));
        s   = (v < 0);
        mag = (v < 0) ? -v : v;
        if (mag > (1 << (DW - 1)) - 1) mag = (1 << (DW - 1)) - 1;
        p  = $clog2(mag + 1) - 1;
        sh = (DW - 2) - p;
        if (sh > (1 << EW) - 1) sh = (1 << EW) - 1;
        ei   = (1 << EW) - 1 - sh;
        norm = mag << sh;
        fi   = norm >> (DW - 1 - FW);
        rb   = (norm >> (DW - 2 - FW)) & 1;
        if (r == RND_HALFUP && rb == 1) fi = fi + 1;
        if (fi == (1 << FW)) begin
            if (ei == (1 << EW) - 1) begin
                fi = (1 << FW) - 1;
            end else begin
                fi = 1 << (FW - 1);
                ei = ei + 1;
            end
        end
        e   = ei[EW-1:0];
        f   = fi[FW-1:0];
        lat = sh + 3;
    endtask

    task automatic run_txn(input string tag, input logic [DW-1:0] d, input logic r,
                           input logic es, input logic [EW-1:0] ee, input logic [FW-1:0] ef,
                           input int elat, input int stall);
        int n;
        int lat;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_rnd   = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        in_rnd   = 1'($urandom);
        check({tag, ":busy"}, 32'(in_ready), 32'd0);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), 32'(elat));
        check({tag, ":valid"}, 32'(out_valid), 32'd1);
        check({tag, ":s"}, 32'(out_s), 32'(es));
        check({tag, ":e"}, 32'(out_e), 32'(ee));
        check({tag, ":f"}, 32'(out_f), 32'(ef));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ":hold_ready"}, 32'(in_ready), 32'd0);
            check({tag, ":hold_out"}, {23'd0, out_s, out_e, out_f}, {23'd0, es, ee, ef});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ":drop_valid"}, 32'(out_valid), 32'd0);
        check({tag, ":back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic          ms;
        logic [EW-1:0] me;
        logic [FW-1:0] mf;
        logic [DW-1:0] rd;
        logic          rr;
        int            ml;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_rnd    = RND_TRUNC;
        out_ready = 1'b0;

        #1;
        check("reset:in_ready", 32'(in_ready), 32'd0);
        check("reset:out_valid", 32'(out_valid), 32'd0);
        check("reset:outputs", {23'd0, out_s, out_e, out_f}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset:ready_after", 32'(in_ready), 32'd1);

        run_txn("v460_rnd", 12'b0100_0110_0000, RND_HALFUP, 1'b0, 3'b111, 4'b1001, 3, 0);
        run_txn("v800_sat", 12'b1000_0000_0000, RND_TRUNC,  1'b1, 3'b111, 4'b1111, 3, 0);
        run_txn("v800_sat_r", 12'b1000_0000_0000, RND_HALFUP, 1'b1, 3'b111, 4'b1111, 3, 0);
        run_txn("vfff",     12'b1111_1111_1111, RND_TRUNC,  1'b1, 3'b000, 4'b0001, 10, 0);
        run_txn("vzero",    12'b0000_0000_0000, RND_HALFUP, 1'b0, 3'b000, 4'b0000, 10, 0);
        run_txn("v02e_rnd", 12'b0000_0010_1110, RND_HALFUP, 1'b0, 3'b010, 4'b1100, 8, 0);
        run_txn("v02e_trn", 12'b0000_0010_1110, RND_TRUNC,  1'b0, 3'b010, 4'b1011, 8, 0);
        run_txn("v03e_ovf", 12'b0000_0011_1110, RND_HALFUP, 1'b0, 3'b011, 4'b1000, 8, 0);
        run_txn("v460_bp",  12'b0100_0110_0000, RND_HALFUP, 1'b0, 3'b111, 4'b1001, 3, 5);

        // Idle with in_valid low: nothing happens.
        in_data = 12'h123;
        repeat (4) @(posedge clk);
        #1;
        check("idle:no_valid", 32'(out_valid), 32'd0);
        check("idle:ready", 32'(in_ready), 32'd1);

        // Reset in the middle of normalisation.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = '0;
        in_rnd   = RND_TRUNC;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst:out_valid", 32'(out_valid), 32'd0);
        check("midrst:in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst:ready_after", 32'(in_ready), 32'd1);
        check("midrst:no_valid", 32'(out_valid), 32'd0);
        run_txn("midrst:next", 12'b0000_0010_1110, RND_HALFUP, 1'b0, 3'b010, 4'b1100, 8, 0);

        for (int i = 0; i < 40; i++) begin
            rd = DW'($urandom);
            // Bias some draws towards small magnitudes to exercise long shifts.
            if (i % 3 == 0) rd = DW'($signed(7'($urandom)));
            rr = 1'($urandom);
            model(rd, rr, ms, me, mf, ml);
            run_txn($sformatf("rand%0d_%03h_%0d", i, rd, rr), rd, rr, ms, me, mf, ml,
                    int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
